// File: rtl/apb_if.sv
// APB bus bundle between a peripheral master and a slave.
//   paddr/psel/penable/pwrite/pwdata/pstrb : master -> slave request
//   prdata/pready/pslverr                   : slave -> master response
interface apb_if #(
  parameter int ADDR_W = 12
) ();
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_coef_bank.sv
// APB coefficient bank: N_CH channels x N_TAP coefficients held in a shadow
// bank (software writable) and an active bank (drives the FIR datapath).
// A COMMIT copies shadow to active one channel per cycle, then pulses
// coef_update. Also holds sticky W1C event status with an interrupt mask and
// a saturating read-to-clear event counter.
// Ports:
//   pclk, prst   : clock, synchronous active-high reset
//   apb          : APB slave (writes 0 wait states, reads 1 wait state)
//   evt          : per-channel event pulses
//   irq          : registered |(STATUS & MASK)
//   coef_act     : active coefficients, ch c tap t at (c*N_TAP+t)*COEF_W
//   coef_update  : one-cycle pulse when a commit completes
// ADDR_W must be at least 10 for the coefficient regions to decode.
module apb_coef_bank #(
  parameter int          ADDR_W   = 12,
  parameter int          N_CH     = 4,
  parameter int          N_TAP    = 8,
  parameter int          COEF_W   = 16,
  parameter logic [15:0] COEF_RST = 16'h0010
) (
  input  logic                         pclk,
  input  logic                         prst,
  apb_if.slave                         apb,
  input  logic [N_CH-1:0]              evt,
  output logic                         irq,
  output logic [N_CH*N_TAP*COEF_W-1:0] coef_act,
  output logic                         coef_update
);
  localparam int                CH_BITS   = N_TAP * COEF_W;
  localparam int                BANK_BITS = N_CH * CH_BITS;
  localparam logic [COEF_W-1:0] RST_C     = COEF_RST[COEF_W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

  state_t               state;
  logic [1:0]           ch;
  logic [BANK_BITS-1:0] shadow;
  logic [BANK_BITS-1:0] active;
  logic [N_CH-1:0]      status;
  logic [N_CH-1:0]      mask;
  logic [15:0]          evt_cnt;
  logic                 rd_wait;   // first access cycle of a read has passed
  logic                 rd_err_q;
  logic [31:0]          prdata_q;

  logic        busy, access, wr_done, wr_ok, rd_cap, rd_done;
  logic        is_reg, is_sh, is_act, coef_ok;
  logic [1:0]  reg_idx, dec_ch;
  logic [3:0]  dec_w;
  logic        lo_ok, hi_ok, wr_err, rd_err, commit_wr, cnt_clr;
  logic [31:0] rd_data;
  logic [N_CH-1:0] w1c;
  int          base;

  // Address decode. Coefficient space: bits [9:8] select bank, [7:6] channel,
  // [5:2] word; everything above bit 9 must be zero.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    reg_idx = apb.paddr[3:2];
    dec_ch  = apb.paddr[7:6];
    dec_w   = apb.paddr[5:2];
    is_reg  = (apb.paddr >> 4) == '0;
    coef_ok = ((apb.paddr >> 10) == '0) && (int'(dec_ch) < N_CH)
              && (int'(dec_w) < N_TAP / 2);
    is_sh   = coef_ok && (apb.paddr[9:8] == 2'b01);
    is_act  = coef_ok && (apb.paddr[9:8] == 2'b10);
    base    = (int'(dec_ch) * N_TAP + 2 * int'(dec_w)) * COEF_W;
  end

  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    rd_err  = 1'b1;
    if (is_reg) begin
      rd_err = 1'b0;
      case (reg_idx)
        2'd0:    rd_data = {30'd0, busy, 1'b0};
        2'd1:    rd_data = 32'(status);
        2'd2:    rd_data = 32'(mask);
        default: rd_data = {16'd0, evt_cnt};
      endcase
    end else if (is_sh) begin
      rd_err  = 1'b0;
      rd_data = (32'(shadow[base+COEF_W +: COEF_W]) << 16) | 32'(shadow[base +: COEF_W]);
    end else if (is_act) begin
      rd_err  = 1'b0;
      rd_data = (32'(active[base+COEF_W +: COEF_W]) << 16) | 32'(active[base +: COEF_W]);
    end
  end

  // Writes complete in the first access cycle unless a commit is running;
  // reads always take exactly one wait state.
  assign busy    = (state != S_IDLE);
  assign access  = apb.psel & apb.penable & ~prst;
  assign wr_done = access & apb.pwrite & ~busy;
  assign rd_cap  = access & ~apb.pwrite & ~rd_wait;
  assign rd_done = access & ~apb.pwrite & rd_wait;
  assign wr_err  = ~((is_reg && (reg_idx != 2'd3)) || is_sh);
  assign wr_ok   = wr_done & ~wr_err;

  assign apb.pready  = wr_done | rd_done;
  assign apb.pslverr = (wr_done & wr_err) | (rd_done & rd_err_q);
  assign apb.prdata  = prdata_q;

  // A coefficient field is written only if every byte lane it spans is enabled.
  assign lo_ok = apb.pstrb[0] & ((COEF_W <= 8) | apb.pstrb[1]);
  assign hi_ok = apb.pstrb[2] & ((COEF_W <= 8) | apb.pstrb[3]);

  assign commit_wr = wr_ok & is_reg & (reg_idx == 2'd0) & apb.pstrb[0] & apb.pwdata[0];
  assign w1c       = (wr_ok && is_reg && (reg_idx == 2'd1) && apb.pstrb[0])
                     ? apb.pwdata[N_CH-1:0] : '0;
  assign cnt_clr   = rd_done & is_reg & (reg_idx == 2'd3);

  // Register file and APB response.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (prst) begin
      // NOTE: both coefficient banks are flop arrays with architected reset
      // values, so they are reset like any other register (not a RAM).
      shadow   <= {(N_CH * N_TAP){RST_C}};
      status   <= '0;
      mask     <= '0;
      evt_cnt  <= '0;
      irq      <= 1'b0;
      rd_wait  <= 1'b0;
      rd_err_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      rd_wait <= rd_cap;
      if (rd_cap) begin
        prdata_q <= rd_data;
        rd_err_q <= rd_err;
      end
      // New events override a simultaneous W1C.
      status <= (status & ~w1c) | evt;
      irq    <= |(status & mask);
      if (wr_ok && is_reg && (reg_idx == 2'd2) && apb.pstrb[0])
        mask <= apb.pwdata[N_CH-1:0];
      if (cnt_clr)
        evt_cnt <= {15'd0, |evt};
      else if ((|evt) && (evt_cnt != 16'hFFFF))
        evt_cnt <= evt_cnt + 16'd1;
      if (wr_ok && is_sh) begin
        if (lo_ok) shadow[base +: COEF_W]        <= apb.pwdata[COEF_W-1:0];
        if (hi_ok) shadow[base+COEF_W +: COEF_W] <= apb.pwdata[16 +: COEF_W];
      end
    end
  end

  // Commit engine: one channel copied per cycle, then a single DONE cycle
  // carrying coef_update. Reset aborts and restores the active bank.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state       <= S_IDLE;
      ch          <= '0;
      coef_update <= 1'b0;
      active      <= {(N_CH * N_TAP){RST_C}};
    end else begin
      coef_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (commit_wr) begin
            state <= S_COPY;
            ch    <= '0;
          end
        end
        S_COPY: begin
          active[int'(ch)*CH_BITS +: CH_BITS] <= shadow[int'(ch)*CH_BITS +: CH_BITS];
          if (int'(ch) == N_CH - 1) begin
            state       <= S_DONE;
            coef_update <= 1'b1;
          end else begin
            ch <= ch + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign coef_act = active;
endmodule

// File: tb/tb_apb_coef_bank.sv
// Self-checking bench for apb_coef_bank: directed APB transfers push their
// expected response into a scoreboard queue; a monitor pops and compares on
// every completed transfer. Side-band outputs are checked inline.
module tb_apb_coef_bank;
  localparam int ADDR_W = 12;
  localparam int N_CH   = 4;
  localparam int N_TAP  = 8;
  localparam int COEF_W = 16;
  localparam int CHB    = N_TAP * COEF_W;
  localparam int BANK   = N_CH * CHB;

  logic              pclk = 1'b0;
  logic              prst;
  logic [N_CH-1:0]   evt;
  logic              irq;
  logic              coef_update;
  logic [BANK-1:0]   coef_act;

  apb_if #(.ADDR_W(ADDR_W)) bus ();

  apb_coef_bank #(
    .ADDR_W(ADDR_W), .N_CH(N_CH), .N_TAP(N_TAP), .COEF_W(COEF_W), .COEF_RST(16'h0010)
  ) dut (
    .pclk        (pclk),
    .prst        (prst),
    .apb         (bus.slave),
    .evt         (evt),
    .irq         (irq),
    .coef_act    (coef_act),
    .coef_update (coef_update)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad   = 0;
  logic [BANK-1:0] exp_sh;
  logic [BANK-1:0] exp_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [BANK-1:0] exp);
    total++;
    if (coef_act !== exp) begin
      bad++;
      $display("FAIL %s: coef_act=%h expected=%h", name, coef_act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [BANK-1:0] b, input int c, input int w);
    return {b[(c*N_TAP+2*w+1)*COEF_W +: 16], b[(c*N_TAP+2*w)*COEF_W +: 16]};
  endfunction

  // Model of a shadow write: each 16-bit tap needs both of its byte strobes.
  task automatic sh_model(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int c, w;
    c = int'(a[7:6]);
    w = int'(a[5:2]);
    if (s[1:0] == 2'b11) exp_sh[(c*N_TAP+2*w)*COEF_W +: 16]   = d[15:0];
    if (s[3:2] == 2'b11) exp_sh[(c*N_TAP+2*w+1)*COEF_W +: 16] = d[31:16];
  endtask

  // Monitor: compare every completed transfer against the scoreboard head.
  always @(negedge pclk) begin
    exp_t e;
    if (bus.psel && bus.penable && bus.pready) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_data) check({e.name, "_data"}, bus.prdata, e.data);
        check({e.name, "_err"}, {31'd0, bus.pslverr}, {31'd0, e.err});
      end
    end
  end

  task automatic apb_xfer(input string name, input bit wr, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s, input bit chk,
                          input logic [31:0] exp_d, input logic exp_e, output int waits);
    exp_t e;
    e.chk_data = chk;
    e.data     = exp_d;
    e.err      = exp_e;
    e.name     = name;
    sb.push_back(e);
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    waits = 0;
    forever begin
      @(negedge pclk);
      if (bus.pready) break;
      waits++;
      if (waits > 40) begin
        check({name, "_timeout"}, 32'd0, 32'd1);
        void'(sb.pop_back());
        break;
      end
    end
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr(input string name, input logic [11:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic err);
    int w;
    apb_xfer(name, 1'b1, a, d, s, 1'b0, '0, err, w);
    check({name, "_waits"}, 32'(w), 32'd0);
    if (!err && a[11:8] == 4'h1) sh_model(a, d, s);
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp_d,
                    input logic err);
    int w;
    apb_xfer(name, 1'b0, a, '0, 4'h0, 1'b1, exp_d, err, w);
    check({name, "_waits"}, 32'(w), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BANK-1:0] old_act, exp_v;
    int w, upd_seen;

    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    evt = '0; prst = 1'b1;
    exp_sh  = {(N_CH*N_TAP){16'h0010}};
    exp_act = exp_sh;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;

    // Reset state
    check("rst_irq",     32'(irq), 32'd0);
    check("rst_upd",     32'(coef_update), 32'd0);
    check("rst_pready",  32'(bus.pready), 32'd0);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    check("rst_prdata",  bus.prdata, 32'd0);
    check_vec("rst_coef_act", exp_act);
    rd("rst_act0", 12'h200, 32'h0010_0010, 1'b0);
    rd("rst_status", 12'h004, 32'h0, 1'b0);

    // Partial-strobe shadow write: only tap0 changes
    wr("sh_strb", 12'h100, 32'hABCD_1234, 4'b0011, 1'b0);
    rd("sh_strb_rb", 12'h100, 32'h0010_1234, 1'b0);
    rd("act_unchanged", 12'h200, 32'h0010_0010, 1'b0);

    // Distinct values in every channel; ch3 last word is the top boundary
    wr("sh_c1", 12'h140, 32'hA1A1_B1B1, 4'hF, 1'b0);
    wr("sh_c2", 12'h180, 32'hA2A2_B2B2, 4'hF, 1'b0);
    wr("sh_c3", 12'h1C0, 32'hA3A3_B3B3, 4'hF, 1'b0);
    wr("sh_c3w3", 12'h1CC, 32'hCAFE_F00D, 4'hF, 1'b0);

    // Commit: channel c lands on edge T+1+c, coef_update high after edge T+N_CH
    old_act = exp_act;
    wr("commit", 12'h000, 32'h1, 4'h1, 1'b0);
    for (int k = 0; k <= N_CH + 1; k++) begin
      if (k > 0) begin
        @(posedge pclk); #1;
      end
      for (int c = 0; c < N_CH; c++)
        exp_v[c*CHB +: CHB] = (c < k) ? exp_sh[c*CHB +: CHB] : old_act[c*CHB +: CHB];
      check_vec($sformatf("commit_step%0d", k), exp_v);
      check($sformatf("upd_step%0d", k), 32'(coef_update), 32'(k == N_CH));
    end
    exp_act = exp_sh;
    rd("ctrl_idle", 12'h000, 32'h0, 1'b0);
    rd("act_c0w0", 12'h200, word_of(exp_act, 0, 0), 1'b0);
    rd("act_c3w3", 12'h2CC, 32'hCAFE_F00D, 1'b0);

    // Reads are not stalled during a commit; BUSY is visible
    wr("commit2", 12'h000, 32'h1, 4'h1, 1'b0);
    rd("ctrl_busy", 12'h000, 32'h2, 1'b0);
    repeat (8) @(posedge pclk);

    // A write issued right after COMMIT stalls until IDLE, lands in shadow only
    wr("commit3", 12'h000, 32'h1, 4'h1, 1'b0);
    exp_act = exp_sh;
    apb_xfer("stall_wr", 1'b1, 12'h100, 32'h5555_6666, 4'hF, 1'b0, '0, 1'b0, w);
    check("stall_waits", 32'(w), 32'(N_CH - 1));
    sh_model(12'h100, 32'h5555_6666, 4'hF);
    check_vec("stall_act_kept", exp_act);
    rd("stall_sh_rb", 12'h100, 32'h5555_6666, 1'b0);
    rd("stall_act_rb", 12'h200, word_of(exp_act, 0, 0), 1'b0);

    // Events, mask and interrupt
    wr("mask", 12'h008, 32'h2, 4'h1, 1'b0);
    @(posedge pclk); #1 evt = 4'b0010;
    @(posedge pclk); #1 evt = 4'b0000;
    @(posedge pclk); #1;
    check("irq_set", 32'(irq), 32'd1);
    rd("status_set", 12'h004, 32'h2, 1'b0);
    fork
      wr("w1c_race", 12'h004, 32'h2, 4'h1, 1'b0);
      begin
        @(posedge pclk); @(posedge pclk); #2 evt = 4'b0010;
        @(posedge pclk); #1 evt = 4'b0000;
      end
    join
    rd("status_setwins", 12'h004, 32'h2, 1'b0);
    wr("w1c_nostrb", 12'h004, 32'h2, 4'b1110, 1'b0);
    rd("status_nostrb", 12'h004, 32'h2, 1'b0);
    wr("w1c", 12'h004, 32'h2, 4'h1, 1'b0);
    rd("status_clr", 12'h004, 32'h0, 1'b0);
    check("irq_clr", 32'(irq), 32'd0);

    // Event counter saturation and read-to-clear
    @(posedge pclk); #1 evt = 4'b0001;
    repeat (70000) @(posedge pclk);
    #1 evt = 4'b0000;
    rd("cnt_sat", 12'h00C, 32'h0000_FFFF, 1'b0);
    fork
      rd("cnt_cleared", 12'h00C, 32'h0, 1'b0);
      begin
        repeat (3) @(posedge pclk);
        #2 evt = 4'b0100;
        @(posedge pclk); #1 evt = 4'b0000;
      end
    join
    rd("cnt_clr_inc", 12'h00C, 32'h1, 1'b0);

    // Error responses
    rd("unmapped", 12'h0F0, 32'hDEAD_BEEF, 1'b1);
    rd("bad_word", 12'h120, 32'hDEAD_BEEF, 1'b1);
    wr("wr_active", 12'h200, 32'h1234_5678, 4'hF, 1'b1);
    rd("active_kept", 12'h200, word_of(exp_act, 0, 0), 1'b0);
    wr("wr_evtcnt", 12'h00C, 32'h0, 4'hF, 1'b1);

    // Reset in the middle of a commit aborts it without coef_update
    wr("commit_abort", 12'h000, 32'h1, 4'h1, 1'b0);
    @(posedge pclk); #1 prst = 1'b1;
    @(posedge pclk); #1 prst = 1'b0;
    exp_sh  = {(N_CH*N_TAP){16'h0010}};
    exp_act = exp_sh;
    check_vec("abort_act_rst", exp_act);
    upd_seen = 0;
    repeat (8) begin
      @(posedge pclk); #1;
      if (coef_update) upd_seen++;
    end
    check("abort_no_upd", 32'(upd_seen), 32'd0);
    rd("abort_sh_rst", 12'h100, 32'h0010_0010, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
